// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM master that copies a block of words within a single-port on-chip RAM.
// Optional running checksum of copied words: define ONCHIP_COPY_CHECKSUM_EN.
module onchip_memory_copy_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_waitrequest
`ifdef ONCHIP_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   index_inc;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] data_q;
  logic              last_word;

  // index is one bit wider than an address so a full-memory copy can terminate
  assign index_inc = index + (ADDR_W + 1)'(1);
  assign last_word = (index_inc == len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? DONE : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!m_waitrequest) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (!m_waitrequest) begin
          state_nxt = last_word ? DONE : RD_ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // latency counter counts down to zero; the zero cycle is the capture cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      index   <= '0;
      lat_cnt <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= length;
            index <= '0;
          end
        end
        RD_ISSUE: begin
          if (!m_waitrequest) begin
            lat_cnt <= LAT_W'(READ_LATENCY - 1);
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            data_q <= m_readdata;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        WR_ISSUE: begin
          if (!m_waitrequest) begin
            index <= index_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ONCHIP_COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == RD_WAIT && lat_cnt == '0) begin
      checksum <= checksum + m_readdata;
    end
  end
`endif

  // bus outputs decode straight from state so an async reset clears them at once
  always_comb begin
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    case (state)
      RD_ISSUE: begin
        m_chipselect = 1'b1;
        m_address    = src_q + index[ADDR_W-1:0];
        m_byteenable = {BE_W{1'b1}};
      end
      WR_ISSUE: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_q + index[ADDR_W-1:0];
        m_byteenable = {BE_W{1'b1}};
        m_writedata  = data_q;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign m_clken = 1'b1;

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Bench for onchip_memory_copy_master: RAM slave with stall control, copy model and scoreboard.
// Build with ONCHIP_COPY_CHECKSUM_EN defined to also check the checksum output.
module tb_onchip_memory_copy_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [9:0]  m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_clken;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
`ifdef ONCHIP_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  onchip_memory_copy_master #(
    .ADDR_W(10),
    .DATA_W(32),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .m_address(m_address),
    .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_clken(m_clken),
    .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
`ifdef ONCHIP_COPY_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } xfer_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];
  logic [31:0] exp_sum;
  xfer_t       exp_q[$];
  logic        prev_stall = 1'b0;
  logic [43:0] prev_vec   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_cs"}, m_chipselect, 0);
    checkOutput({tag, "_write"}, m_write, 0);
    checkOutput({tag, "_addr"}, m_address, 0);
    checkOutput({tag, "_be"}, m_byteenable, 0);
    checkOutput({tag, "_wdata"}, m_writedata, 0);
    checkOutput({tag, "_clken"}, m_clken, 1);
`ifdef ONCHIP_COPY_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  // Scoreboard: every accepted transfer must match the next one the copy model predicts,
  // and a stalled transfer must be presented unchanged on the following cycle.
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      checkOutput("clken", m_clken, 1);
      checkOutput("byteenable", m_byteenable, m_chipselect ? 4'hF : 4'h0);
      if (prev_stall) begin
        checkOutput("stall_hold", {m_chipselect, m_write, m_address, m_writedata}, prev_vec);
      end
      if (m_chipselect && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_xfer", {m_write, m_address}, 0);
        end else begin
          xfer_t t;
          t = exp_q.pop_front();
          checkOutput("xfer", {21'b0, m_write, m_address, (m_write ? m_writedata : 32'h0)},
                      {21'b0, t.wr, t.addr, t.data});
        end
      end
      prev_stall = m_chipselect && m_waitrequest;
      prev_vec   = {m_chipselect, m_write, m_address, m_writedata};
    end
  end

  // Runs one copy acting as the RAM slave; call on a falling edge with the DUT idle.
  task automatic applyStimulus(input logic [9:0] src, input logic [9:0] dst, input logic [10:0] len,
                               input int stall_rd, input int stall_wr, input int mid_start,
                               input int reset_wr, output int done_cyc, output int done_cnt,
                               output int busy_cnt, output int cs_cnt);
    logic [9:0]  r;
    logic [9:0]  w;
    logic [31:0] d;
    logic        rd_pend;
    logic [9:0]  rd_addr;
    int          rdn;
    int          wrn;
    int          rd_left;
    int          wr_left;
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    cs_cnt   = 0;
    rd_pend  = 1'b0;
    rd_addr  = '0;
    rdn      = 0;
    wrn      = 0;
    rd_left  = (stall_rd >= 0) ? 3 : 0;
    wr_left  = (stall_wr >= 0) ? 3 : 0;
    // copy model: ascending word-by-word copy with wrapping addresses
    for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
    exp_sum = '0;
    for (int i = 0; i < int'(len); i++) begin
      r = src + 10'(i);
      w = dst + 10'(i);
      d = exp_mem[r];
      exp_q.push_back('{1'b0, r, 32'h0});
      exp_q.push_back('{1'b1, w, d});
      exp_mem[w] = d;
      exp_sum = exp_sum + d;
    end
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    length   = len;
    @(negedge clk);
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      m_waitrequest = 1'b0;
      if (rd_pend) begin
        m_readdata = mem[rd_addr];
        rd_pend = 1'b0;
      end else begin
        m_readdata = 32'hDEADBEEF;
      end
      start    = (cyc == mid_start);
      src_addr = 10'h2AA;
      dst_addr = 10'h155;
      length   = 11'd7;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (m_chipselect) begin
        cs_cnt++;
        if (m_write && wrn == reset_wr) begin
          reset_n = 1'b0;
          #1;
          checkResetValues("abort");
          repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
          end
          reset_n = 1'b1;
          start = 1'b0;
          return;
        end
        if (!m_write && rdn == stall_rd && rd_left > 0) begin
          m_waitrequest = 1'b1;
          rd_left--;
        end else if (m_write && wrn == stall_wr && wr_left > 0) begin
          m_waitrequest = 1'b1;
          wr_left--;
        end else if (m_write) begin
          for (int b = 0; b < 4; b++) begin
            if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
          end
          wrn++;
        end else begin
          rd_pend = 1'b1;
          rd_addr = m_address;
          rdn++;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      @(negedge clk);
    end
    start = 1'b0;
    m_waitrequest = 1'b0;
  endtask

  task automatic runCase(input string name, input logic [9:0] src, input logic [9:0] dst,
                         input logic [10:0] len, input int stall_rd, input int stall_wr,
                         input int mid_start, input int exp_done, output int cs_cnt);
    int done_cyc;
    int done_cnt;
    int busy_cnt;
    int mism;
    applyStimulus(src, dst, len, stall_rd, stall_wr, mid_start, -1, done_cyc, done_cnt, busy_cnt, cs_cnt);
    checkOutput({name, "_done_cycle"}, done_cyc, exp_done);
    checkOutput({name, "_done_pulses"}, done_cnt, 1);
    checkOutput({name, "_busy_cycles"}, busy_cnt, exp_done);
    checkOutput({name, "_xfers_left"}, exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) mism++;
    checkOutput({name, "_mem_image"}, mism, 0);
`ifdef ONCHIP_COPY_CHECKSUM_EN
    checkOutput({name, "_checksum"}, checksum, exp_sum);
`endif
  endtask

  initial begin
    int          cs_cnt;
    int          done_cyc;
    int          done_cnt;
    int          busy_cnt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    reset_n       = 1'b0;
    start         = 1'b0;
    src_addr      = '0;
    dst_addr      = '0;
    length        = '0;
    m_readdata    = '0;
    m_waitrequest = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h0BADF00D;
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] length 4 copy");
    runCase("len4", 10'h000, 10'h100, 11'd4, -1, -1, -1, 13, cs_cnt);
    checkOutput("len4_w0", mem[10'h100], 32'h11111111);
    checkOutput("len4_w1", mem[10'h101], 32'h22222222);
    checkOutput("len4_w2", mem[10'h102], 32'h33333333);
    checkOutput("len4_w3", mem[10'h103], 32'h44444444);
`ifdef ONCHIP_COPY_CHECKSUM_EN
    checkOutput("len4_sum_literal", checksum, 32'hAAAAAAAA);
`endif

    $display("[TB] length 0");
    runCase("len0", 10'h010, 10'h020, 11'd0, -1, -1, -1, 1, cs_cnt);
    checkOutput("len0_no_cs", cs_cnt, 0);

    $display("[TB] address wrap");
    a = mem[10'h3FE];
    b = mem[10'h3FF];
    c = mem[10'h000];
    runCase("wrap", 10'h3FE, 10'h001, 11'd3, -1, -1, -1, 10, cs_cnt);
    checkOutput("wrap_w0", mem[10'h001], a);
    checkOutput("wrap_w1", mem[10'h002], b);
    checkOutput("wrap_w2", mem[10'h003], c);

    $display("[TB] waitrequest stalls");
    runCase("stall", 10'h010, 10'h020, 11'd4, 1, 0, -1, 19, cs_cnt);

    $display("[TB] start while busy");
    runCase("busystart", 10'h040, 10'h080, 11'd3, -1, -1, 4, 10, cs_cnt);

    $display("[TB] overlapping forward copy");
    a = mem[10'h300];
    runCase("overlap", 10'h300, 10'h301, 11'd4, -1, -1, -1, 13, cs_cnt);
    checkOutput("overlap_w3", mem[10'h304], a);

    $display("[TB] reset during second write");
    a = mem[10'h050];
    b = mem[10'h061];
    applyStimulus(10'h050, 10'h060, 11'd4, -1, -1, -1, 1, done_cyc, done_cnt, busy_cnt, cs_cnt);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_w0_kept", mem[10'h060], a);
    checkOutput("abort_w1_untouched", mem[10'h061], b);
    runCase("after_abort", 10'h070, 10'h0A0, 11'd2, -1, -1, -1, 7, cs_cnt);

    $display("[TB] full memory copy");
    runCase("full", 10'h000, 10'h200, 11'd1024, -1, -1, -1, 3073, cs_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
